scr1_tb_imem_responder: RTL and testbench

- Testbench-side instruction-memory responder: the target end of the core's imem request/response interface.
- Accepts pipelined fetch requests from the core and returns words from an internal memory image after a fixed latency, in order.
- Reports ERROR for illegal accesses.
- Counts delivered ADDI words (opcode 7'b0010011, funct3 3'b000) so benches can cross-check fetch-side monitors.

---
 rtl/scr1_tb_imem_pkg.sv | 26 ++
 rtl/scr1_tb_imem_req_fifo.sv | 82 ++++++++
 rtl/scr1_tb_imem_responder.sv | 111 +++++++++++
 tb/tb_scr1_tb_imem_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tb_imem_pkg.sv
// Shared constants and types for the testbench-side imem responder.
package scr1_tb_imem_pkg;

    localparam logic [1:0] RespIdle  = 2'b00;
    localparam logic [1:0] RespOkay  = 2'b01;
    localparam logic [1:0] RespError = 2'b10;

    localparam logic CmdRd = 1'b0;
    localparam logic CmdWr = 1'b1;

    localparam logic [6:0] AddiOpcode = 7'b0010011;
    localparam logic [2:0] AddiFunct3 = 3'b000;

    localparam logic [15:0] LfsrSeed = 16'hACE1;

    typedef struct packed {
        logic [31:0] addr;
        logic        cmd;
        logic [2:0]  timer;
    } imem_entry_t;

    function automatic logic is_addi(input logic [31:0] word);
        return (word[6:0] == AddiOpcode) && (word[14:12] == AddiFunct3);
    endfunction

endpackage

// File: rtl/scr1_tb_imem_req_fifo.sv
// In-order request FIFO; every entry carries a countdown timer and the head is
// ready to issue when its timer reads 1.
module scr1_tb_imem_req_fifo
    import scr1_tb_imem_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned Latency = 2,
    localparam int unsigned CntW   = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [31:0]       push_addr_i,
    input  logic              push_cmd_i,
    input  logic              pop_i,
    output logic              full_o,
    output imem_entry_t       head_o,
    output logic              head_ready_o,
    output logic [CntW-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    imem_entry_t     ent_q [Depth];
    imem_entry_t     ent_d [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o       = (count_q == CntW'(Depth));
    assign head_o       = ent_q[rd_ptr_q];
    assign head_ready_o = (count_q != '0) && (ent_q[rd_ptr_q].timer == 3'd1);
    assign count_o      = count_q;

    // Pushes are blocked while full even if the head pops this cycle.
    assign push = push_i & ~full_o;
    assign pop  = pop_i & head_ready_o;

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < Depth; i++) begin
            if (ent_q[i].timer != 3'd0) begin
                ent_d[i].timer = ent_q[i].timer - 3'd1;
            end
        end
        if (push) begin
            ent_d[wr_ptr_q].addr  = push_addr_i;
            ent_d[wr_ptr_q].cmd   = push_cmd_i;
            ent_d[wr_ptr_q].timer = 3'(Latency);
        end
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                ent_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/scr1_tb_imem_responder.sv
// Target end of the core imem interface: fixed-latency in-order responses from
// a preloadable image. Define SCR1_TB_IMEM_STALL_EN for LFSR-driven back-pressure.
module scr1_tb_imem_responder
    import scr1_tb_imem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               imem_req,
    input  logic                               imem_cmd,
    input  logic [31:0]                        imem_addr,
    output logic                               imem_req_ack,
    output logic [31:0]                        imem_rdata,
    output logic [1:0]                         imem_resp,
    input  logic                               load_we,
    input  logic [31:0]                        load_addr,
    input  logic [31:0]                        load_data,
    output logic [31:0]                        addi_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    outstanding
);

    localparam int unsigned MemAw    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [33:0] MemBytes = 34'(MEM_WORDS) << 2;

    logic [31:0] mem [MEM_WORDS];

    logic              full;
    logic              head_ready;
    imem_entry_t       head;
    logic              head_ok;
    logic [MemAw-1:0]  head_idx;
    logic [31:0]       mem_word;

    logic [1:0]  resp_q;
    logic [31:0] rdata_q;
    logic [31:0] addi_cnt_q;

`ifdef SCR1_TB_IMEM_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end

    assign imem_req_ack = ~full & ~lfsr_q[0];
`else
    assign imem_req_ack = ~full;
`endif

    scr1_tb_imem_req_fifo #(
        .Depth   (FIFO_DEPTH),
        .Latency (LATENCY)
    ) u_req_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (imem_req & imem_req_ack),
        .push_addr_i  (imem_addr),
        .push_cmd_i   (imem_cmd),
        .pop_i        (head_ready),
        .full_o       (full),
        .head_o       (head),
        .head_ready_o (head_ready),
        .count_o      (outstanding)
    );

    always_comb begin
        head_ok  = (head.cmd == CmdRd) && (head.addr[1:0] == 2'b00) &&
                   ({2'b00, head.addr} < MemBytes);
        head_idx = head.addr[MemAw+1:2];
        mem_word = mem[head_idx];
    end

    // Backdoor writes land after the same-edge read, so responses see old data.
    always_ff @(posedge clk) begin
        if (load_we && (load_addr < 32'(MEM_WORDS))) begin
            mem[load_addr[MemAw-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q     <= RespIdle;
            rdata_q    <= '0;
            addi_cnt_q <= '0;
        end else if (head_ready) begin
            resp_q  <= head_ok ? RespOkay : RespError;
            rdata_q <= head_ok ? mem_word : 32'd0;
            if (head_ok && is_addi(mem_word)) begin
                addi_cnt_q <= addi_cnt_q + 32'd1;
            end
        end else begin
            resp_q  <= RespIdle;
            rdata_q <= '0;
        end
    end

    assign imem_resp  = resp_q;
    assign imem_rdata = rdata_q;
    assign addi_cnt   = addi_cnt_q;

endmodule

// File: tb/tb_scr1_tb_imem_responder.sv
// Self-checking bench: three responder configurations against a transaction-level model.
module tb_scr1_tb_imem_responder;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        req   [3];
    logic        cmd   [3];
    logic [31:0] addr  [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic [1:0]  resp  [3];
    logic [31:0] acnt  [3];
    logic [2:0]  out_a;
    logic [1:0]  out_b;
    logic [2:0]  out_c;

    // Model state: accepted-but-unanswered requests per DUT, with their due cycle.
    int          lat [3] = '{2, 4, 4};
    int          dep [3] = '{4, 2, 4};
    logic [31:0] pend_addr [3][16];
    logic        pend_cmd  [3][16];
    int          pend_due  [3][16];
    int          head [3];
    int          tail [3];
    logic        accepted [3];
    logic [31:0] exp_cnt [3];
    logic [31:0] shadow [MW];
    logic [15:0] lfsr_m;
    int          cyc;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    scr1_tb_imem_responder #(.MEM_WORDS(MW), .LATENCY(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .imem_req(req[0]), .imem_cmd(cmd[0]), .imem_addr(addr[0]),
        .imem_req_ack(ack[0]), .imem_rdata(rdata[0]), .imem_resp(resp[0]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .addi_cnt(acnt[0]), .outstanding(out_a)
    );

    scr1_tb_imem_responder #(.MEM_WORDS(MW), .LATENCY(4), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .imem_req(req[1]), .imem_cmd(cmd[1]), .imem_addr(addr[1]),
        .imem_req_ack(ack[1]), .imem_rdata(rdata[1]), .imem_resp(resp[1]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .addi_cnt(acnt[1]), .outstanding(out_b)
    );

    scr1_tb_imem_responder #(.MEM_WORDS(MW), .LATENCY(4), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .imem_req(req[2]), .imem_cmd(cmd[2]), .imem_addr(addr[2]),
        .imem_req_ack(ack[2]), .imem_rdata(rdata[2]), .imem_resp(resp[2]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .addi_cnt(acnt[2]), .outstanding(out_c)
    );

    function automatic int get_out(input int d);
        if (d == 0) return int'(out_a);
        if (d == 1) return int'(out_b);
        return int'(out_c);
    endfunction

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; cmd[d] = 1'b0; addr[d] = '0;
        end
        load_we = 1'b0;
    endtask

    // One clock of all three DUTs, checked against the model.
    task automatic step();
        logic        exp_ack;
        logic [1:0]  er;
        logic [31:0] ed;
        logic [31:0] a;
        int          slot;
        for (int d = 0; d < 3; d++) begin
            exp_ack = (tail[d] - head[d]) < dep[d];
`ifdef SCR1_TB_IMEM_STALL_EN
            exp_ack = exp_ack && !lfsr_m[0];
`endif
            n_checks++;
            if (ack[d] !== exp_ack) begin
                n_fail++;
                $display("FAIL ack dut%0d cyc%0d: got %b want %b", d, cyc, ack[d], exp_ack);
            end
            accepted[d] = req[d] && exp_ack;
            if (accepted[d]) begin
                slot = tail[d] % 16;
                pend_addr[d][slot] = addr[d];
                pend_cmd[d][slot]  = cmd[d];
                pend_due[d][slot]  = cyc + 1 + lat[d];
                tail[d]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
`ifdef SCR1_TB_IMEM_STALL_EN
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
        for (int d = 0; d < 3; d++) begin
            er = 2'b00;
            ed = 32'd0;
            slot = head[d] % 16;
            if (tail[d] > head[d] && pend_due[d][slot] == cyc) begin
                a = pend_addr[d][slot];
                if (!pend_cmd[d][slot] && a[1:0] == 2'b00 && a < 32'(MW * 4)) begin
                    er = 2'b01;
                    ed = shadow[a >> 2];
                    if (ed[6:0] == 7'h13 && ed[14:12] == 3'd0) exp_cnt[d]++;
                end else begin
                    er = 2'b10;
                end
                head[d]++;
            end
            n_checks++;
            if (resp[d] !== er) begin
                n_fail++;
                $display("FAIL resp dut%0d cyc%0d: got %b want %b", d, cyc, resp[d], er);
            end
            n_checks++;
            if (rdata[d] !== ed) begin
                n_fail++;
                $display("FAIL rdata dut%0d cyc%0d: got %h want %h", d, cyc, rdata[d], ed);
            end
            n_checks++;
            if (acnt[d] !== exp_cnt[d]) begin
                n_fail++;
                $display("FAIL addi_cnt dut%0d cyc%0d: got %0d want %0d", d, cyc, acnt[d],
                         exp_cnt[d]);
            end
            n_checks++;
            if (get_out(d) != tail[d] - head[d]) begin
                n_fail++;
                $display("FAIL outstanding dut%0d cyc%0d: got %0d want %0d", d, cyc,
                         get_out(d), tail[d] - head[d]);
            end
        end
        if (load_we && load_addr < 32'(MW)) shadow[load_addr] = load_data;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            head[d] = 0; tail[d] = 0; exp_cnt[d] = '0;
        end
        lfsr_m = 16'hACE1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        idle_inputs();
        load_we = 1'b1; load_addr = 32'(idx); load_data = data;
        step();
        load_we = 1'b0;
    endtask

    task automatic drain();
        int busy;
        idle_inputs();
        for (int n = 0; n < 40; n++) begin
            busy = 0;
            for (int d = 0; d < 3; d++) if (tail[d] > head[d]) busy = 1;
            if (busy == 0) break;
            step();
        end
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (tail[d] != head[d]) begin
                n_fail++;
                $display("FAIL drain_timeout dut%0d: got %0d pending want 0", d,
                         tail[d] - head[d]);
            end
        end
    endtask

    function automatic logic [31:0] rand_word(input logic make_addi);
        logic [31:0] w;
        w = $urandom;
        if (make_addi) begin
            w[6:0] = 7'h13; w[14:12] = 3'd0;
        end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
            w[12] = 1'b1;
        end
        return w;
    endfunction

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (resp[d] !== 2'b00 || rdata[d] !== 32'd0 || acnt[d] !== 32'd0 ||
                get_out(d) != 0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got resp %b rdata %h cnt %0d out %0d want 0",
                         d, resp[d], rdata[d], acnt[d], get_out(d));
            end
        end
    endtask

    task automatic test_single_addi();
        load_word(0, 32'h0050_0093);
        req[0] = 1'b1; addr[0] = 32'h0;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (resp[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL single_early: got resp %b want 00", resp[0]);
        end
        step();
        n_checks++;
        if (resp[0] !== 2'b01 || rdata[0] !== 32'h0050_0093 || acnt[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL single_addi: got resp %b rdata %h cnt %0d want 01 00500093 1",
                     resp[0], rdata[0], acnt[0]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int peak;
        load_word(1, 32'h0010_8113);
        load_word(2, 32'h0000_0033);
        load_word(3, 32'hFFF1_0193);
        peak = 0;
        for (int k = 0; k < 4; k++) begin
            req[0] = 1'b1; addr[0] = 32'(k * 4);
            n_checks++;
            if (ack[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ack k%0d: got %b want 1", k, ack[0]);
            end
            step();
            if (int'(out_a) > peak) peak = int'(out_a);
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            if (int'(out_a) > peak) peak = int'(out_a);
        end
        n_checks++;
        if (peak != 2) begin
            n_fail++;
            $display("FAIL b2b_peak: got %0d want 2", peak);
        end
        drain();
    endtask

    task automatic test_errors();
        logic [31:0] cnt0;
        cnt0 = acnt[0];
        req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 32'h2;    step();
        req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 32'h1000; step();
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h0;    step();
        drain();
        n_checks++;
        if (acnt[0] !== cnt0) begin
            n_fail++;
            $display("FAIL errors_cnt: got %0d want %0d", acnt[0], cnt0);
        end
    endtask

    task automatic test_backpressure();
        int peak;
        int k;
        peak = 0;
        k = 0;
        for (int n = 0; n < 16; n++) begin
            req[1] = 1'b1; addr[1] = 32'((k % 4) * 4);
            step();
            if (accepted[1]) k++;
            if (int'(out_b) > peak) peak = int'(out_b);
        end
        drain();
        n_checks++;
        if (peak != 2) begin
            n_fail++;
            $display("FAIL bp_peak: got %0d want 2", peak);
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            req[2] = 1'b1; addr[2] = 32'(k * 4);
            step();
        end
        do_reset();
        for (int n = 0; n < 6; n++) step();
        n_checks++;
        if (out_c !== 3'd0 || acnt[2] !== 32'd0) begin
            n_fail++;
            $display("FAIL midflight_reset: got out %0d cnt %0d want 0 0", out_c, acnt[2]);
        end
        req[2] = 1'b1; addr[2] = 32'h0;
        step();
        drain();
        n_checks++;
        if (acnt[2] !== 32'd1) begin
            n_fail++;
            $display("FAIL midflight_new_read: got cnt %0d want 1", acnt[2]);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 64; i++) load_word(i, rand_word($urandom_range(0, 1) == 1));
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) begin
                req[d] = ($urandom_range(0, 9) < 7);
                kind = $urandom_range(0, 7);
                cmd[d] = (kind == 7);
                addr[d] = 32'($urandom_range(0, 63) * 4);
                if (kind == 5) addr[d] = addr[d] | 32'($urandom_range(1, 3));
                if (kind == 6) addr[d] = 32'h1000 + 32'($urandom_range(0, 4095));
            end
            load_we = ($urandom_range(0, 9) == 0);
            load_addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) load_addr = load_addr + 32'(MW);
            load_data = rand_word($urandom_range(0, 1) == 1);
            step();
        end
        drain();
    endtask

`ifdef SCR1_TB_IMEM_STALL_EN
    task automatic test_stall();
        int k;
        for (int i = 0; i < 100; i++) load_word(i, rand_word($urandom_range(0, 1) == 1));
        k = 0;
        for (int n = 0; n < 2000 && k < 100; n++) begin
            req[0] = 1'b1; addr[0] = 32'(k * 4);
            step();
            if (accepted[0]) k++;
        end
        drain();
        n_checks++;
        if (k != 100) begin
            n_fail++;
            $display("FAIL stall_accepts: got %0d want 100", k);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        lfsr_m = 16'hACE1;
        idle_inputs();
        test_reset();
`ifdef SCR1_TB_IMEM_STALL_EN
        test_stall();
`else
        test_single_addi();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
